rst_sequencer: RTL and testbench
================================

# rst_sequencer

Multi-channel power-on / soft reset sequencer: releases CH_NUM active-low reset outputs one after another at programmable cycle offsets after the system reset deasserts. It supports a software re-sequence request and a hold input that freezes sequencing. The block sits at the top of the clock domain, between the board or PLL-lock reset and the per-subsystem resets (DDR, sensor, video pipe, …).

## Interface
- CH_NUM, 4, number of reset channels (1..16)
- CNT_W, 32, counter width in bits
- FIRST, 32'h00ff_ff00, cycle threshold for channel 0 release
- STEP, 32'h0000_1000, extra cycles between successive channel releases
- Constraint: T_k = FIRST + k*STEP. T_last = T_(CH_NUM-1) must be < 2^CNT_W − 1. Violation is an elaboration error.

- i_clk  in  1  clock; all logic on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_req  in  1  re-sequence request, sampled each cycle, level-valid
- i_hold  in  1  freeze counter and outputs while high
- o_rstn  out  CH_NUM  per-channel active-low reset, registered
- o_busy  out  1  high while sequencing (S_CNT or S_DOWN)
- o_done  out  1  one-cycle pulse on entry to S_DONE
- o_cnt  out  CNT_W  current counter value

## Operation
- **States:**
  - S_CNT: release sequence running.
  - S_DONE: all channels released.
  - S_DOWN: ordered assertion; exists only with the macro enabled.
- **Reset (i_rst=1):**
  - Next edge: state=S_CNT, cnt=0, o_rstn=0, o_done=0, o_busy=0.
- **S_CNT:**
  - o_busy=1.
  - cnt increments by 1 while cnt < T_last, then saturates.
  - o_rstn[k] <= (cnt >= T_k), using the pre-increment cnt.
  - When cnt == T_last: state→S_DONE, o_done<=1 for one cycle.
- **S_DONE:**
  - o_busy=0, cnt holds, o_rstn all ones.
  - i_hold is ignored.
- **i_req:**
  - In S_CNT: restart. Next edge: cnt=0, o_rstn=0, stay in S_CNT.
  - In S_DONE: begin the down sequence (see Configuration).
  - In S_DOWN: ignored.
- **i_hold (S_CNT/S_DOWN):** cnt, o_rstn and state are frozen. o_busy stays 1. o_done stays 0.
- **Priority:** i_rst > i_req > i_hold.
  - i_req and i_hold together: the restart takes effect, and the hold then freezes cnt at 0.
- Comparisons are unsigned at CNT_W. Thresholds are elaboration-time constants; no runtime multiplier.

## Timing
- Edge 0 = last edge sampling i_rst=1. At edge n (n≥1, no hold/req), cnt=n.
- o_rstn[k] rises at edge T_k+1.
- o_done pulses at edge T_last+1, in the same cycle that o_rstn[CH_NUM-1] rises.
- o_busy rises at edge 1 and falls at edge T_last+1.
- Each hold cycle delays all subsequent events by exactly one cycle.
- i_req in S_CNT: o_rstn all zero one edge later. Release timing then follows as if edge 0 had been the req edge.
- Reset mid-sequence: outputs return to their reset values on the next edge, whatever the state.

## Configuration
- **Macro: RST_SEQ_ORDERED_ASSERT_EN.**
- **Defined:** i_req in S_DONE → S_DOWN with cnt=0.
  - o_rstn[k] clears at the edge after cnt reaches (CH_NUM-1-k)*STEP. Highest channel first; channels go down in reverse order.
  - When cnt == (CH_NUM-1)*STEP: next edge clears o_rstn[0], state→S_CNT, cnt=0.
  - i_hold freezes S_DOWN.
- **Not defined:** i_req in S_DONE acts as a restart. Next edge: o_rstn=0, cnt=0, state=S_CNT. No S_DOWN state is built.

## Test plan
All scenarios use CH_NUM=4, FIRST=10, STEP=5, CNT_W=8, so T=10,15,20,25.
- **Power-on:** i_rst high 3 cycles, then low.
  - o_rstn = 0001 @ edge 11, 0011 @16, 0111 @21, 1111 @26.
  - o_done high only during edge 26..27.
  - o_cnt saturates at 25.
- **Hold:** i_hold high for 4 cycles starting at edge 12.
  - o_cnt stays at 11 over those 4 cycles.
  - o_rstn[1] rises @20, o_done @30.
- **Restart in S_CNT:** i_req pulse at edge 17.
  - o_rstn=0000 and o_cnt=0 @18.
  - o_rstn[0] rises @29.
- **Req in S_DONE, macro off:**
  - o_rstn=0000 one edge after req.
  - Full release sequence repeats with the same offsets.
- **Req in S_DONE, macro on:**
  - o_rstn = 0111 @+1, 0011 @+6, 0001 @+11, 0000 @+16.
  - Release restarts with o_rstn[0] rising 11 edges after that.
- **Reset mid-sequence:** i_rst at edge 22.
  - o_rstn=0000, o_busy=0, o_cnt=0 @23.
  - No o_done pulse.

Source files
------------

// File: rtl/rst_sequencer.sv
// rst_sequencer: staggered release of CH_NUM active-low resets; optional ordered assert via RST_SEQ_ORDERED_ASSERT_EN
module rst_sequencer #(
    parameter int unsigned     CH_NUM = 4,
    parameter int unsigned     CNT_W  = 32,
    parameter longint unsigned FIRST  = 64'h0000_0000_00ff_ff00,
    parameter longint unsigned STEP   = 64'h0000_0000_0000_1000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_hold,
    output logic [CH_NUM-1:0] o_rstn,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_cnt
);
    localparam longint unsigned T_LAST_L = FIRST + 64'(CH_NUM - 1) * STEP;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(T_LAST_L);
    if (CH_NUM < 1 || CH_NUM > 16 || CNT_W < 1 || CNT_W > 63 ||
        T_LAST_L >= (64'd1 << CNT_W) - 64'd1) begin : g_bad_cfg
        $error("rst_sequencer: last release threshold does not fit below 2^CNT_W-1");
    end
`ifdef RST_SEQ_ORDERED_ASSERT_EN
    localparam int ST_W = 2;
`else
    localparam int ST_W = 1;
`endif
    localparam logic [ST_W-1:0] S_CNT  = ST_W'(0);
    localparam logic [ST_W-1:0] S_DONE = ST_W'(1);
`ifdef RST_SEQ_ORDERED_ASSERT_EN
    localparam logic [ST_W-1:0] S_DOWN = ST_W'(2);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(64'(CH_NUM - 1) * STEP);
    logic [CH_NUM-1:0] clr;
`endif
    logic [ST_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_NUM-1:0] rstn_q, rstn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CH_NUM-1:0] rel;
    logic              at_last;

    // Per-channel thresholds are constants, so each compare is a fixed comparator
    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        localparam logic [CNT_W-1:0] TK = CNT_W'(FIRST + 64'(k) * STEP);
        assign rel[k] = cnt_q >= TK;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
        localparam logic [CNT_W-1:0] DK = CNT_W'(64'(CH_NUM - 1 - k) * STEP);
        assign clr[k] = cnt_q == DK;
`endif
    end

    assign at_last = cnt_q == T_LAST;

    // Next-state: req beats hold; in the down phase a channel, once cleared, stays cleared
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        done_d  = 1'b0;
        if (state_q == S_CNT) begin
            if (i_req) begin
                cnt_d  = '0;
                rstn_d = '0;
            end else if (!i_hold) begin
                cnt_d   = at_last ? cnt_q : cnt_q + CNT_W'(1);
                rstn_d  = rel;
                state_d = at_last ? S_DONE : S_CNT;
                done_d  = at_last;
            end
        end else if (state_q == S_DONE) begin
            rstn_d = '1;
            if (i_req) begin
                cnt_d = '0;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
                state_d = S_DOWN;
`else
                state_d = S_CNT;
                rstn_d  = '0;
`endif
            end
        end
`ifdef RST_SEQ_ORDERED_ASSERT_EN
        else if (!i_hold) begin
            cnt_d   = (cnt_q == D_LAST) ? '0 : cnt_q + CNT_W'(1);
            rstn_d  = (cnt_q == D_LAST) ? '0 : rstn_q & ~clr;
            state_d = (cnt_q == D_LAST) ? S_CNT : S_DOWN;
        end
`endif
    end

    assign busy_d = state_d != S_DONE;

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_CNT;
            cnt_q   <= '0;
            rstn_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_rstn = rstn_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_cnt  = cnt_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: directed checks of release timing, hold, restart, down sequence and reset
module tb_rst_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1, req = 1'b0, hold = 1'b0;
    logic [3:0] rstn;
    logic       busy, done;
    logic [7:0] cnt;
    int         n_cmp = 0, n_bad = 0;
    int         e = 0;

    rst_sequencer #(.CH_NUM(4), .CNT_W(8), .FIRST(10), .STEP(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_hold(hold),
        .o_rstn(rstn), .o_busy(busy), .o_done(done), .o_cnt(cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go(input int n);
        while (e < n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        e = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, e, obs, exp);
        end
    endtask

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        e = 0;
        chk("por_rstn", 32'(rstn), 32'h0);
        chk("por_busy", 32'(busy), 32'h0);
        chk("por_done", 32'(done), 32'h0);
        chk("por_cnt",  32'(cnt),  32'd0);
        go(1);  chk("e1_busy", 32'(busy), 32'h1); chk("e1_cnt", 32'(cnt), 32'd1);
        go(10); chk("e10_rstn", 32'(rstn), 32'h0); chk("e10_cnt", 32'(cnt), 32'd10);
        go(11); chk("e11_rstn", 32'(rstn), 32'h1);
        go(15); chk("e15_rstn", 32'(rstn), 32'h1);
        go(16); chk("e16_rstn", 32'(rstn), 32'h3);
        go(21); chk("e21_rstn", 32'(rstn), 32'h7);
        go(25); chk("e25_rstn", 32'(rstn), 32'h7); chk("e25_done", 32'(done), 32'h0);
        chk("e25_busy", 32'(busy), 32'h1);
        go(26); chk("e26_rstn", 32'(rstn), 32'hf); chk("e26_done", 32'(done), 32'h1);
        chk("e26_busy", 32'(busy), 32'h0); chk("e26_cnt", 32'(cnt), 32'd25);
        hold = 1'b1;
        go(27); chk("e27_done", 32'(done), 32'h0); chk("e27_cnt", 32'(cnt), 32'd25);
        go(28); chk("done_hold_rstn", 32'(rstn), 32'hf); chk("done_hold_busy", 32'(busy), 32'h0);
        hold = 1'b0;
        go(40); chk("e40_cnt", 32'(cnt), 32'd25); chk("e40_rstn", 32'(rstn), 32'hf);
        req = 1'b1;
        go(41);
        req = 1'b0;
`ifdef RST_SEQ_ORDERED_ASSERT_EN
        chk("dn0_rstn", 32'(rstn), 32'hf); chk("dn0_cnt", 32'(cnt), 32'd0);
        chk("dn0_busy", 32'(busy), 32'h1);
        go(42); chk("dn1_rstn", 32'(rstn), 32'h7);
        go(46); chk("dn5_rstn", 32'(rstn), 32'h7);
        go(47); chk("dn6_rstn", 32'(rstn), 32'h3);
        go(52); chk("dn11_rstn", 32'(rstn), 32'h1);
        go(56); chk("dn15_rstn", 32'(rstn), 32'h1);
        go(57); chk("dn16_rstn", 32'(rstn), 32'h0); chk("dn16_cnt", 32'(cnt), 32'd0);
        go(67); chk("up10_rstn", 32'(rstn), 32'h0);
        go(68); chk("up11_rstn", 32'(rstn), 32'h1);
`else
        chk("rq_rstn", 32'(rstn), 32'h0); chk("rq_cnt", 32'(cnt), 32'd0);
        chk("rq_busy", 32'(busy), 32'h1);
        go(51); chk("rq10_rstn", 32'(rstn), 32'h0);
        go(52); chk("rq11_rstn", 32'(rstn), 32'h1);
        go(66); chk("rq25_done", 32'(done), 32'h0);
        go(67); chk("rq26_rstn", 32'(rstn), 32'hf); chk("rq26_done", 32'(done), 32'h1);
`endif
        do_reset();
        go(11); chk("h11_cnt", 32'(cnt), 32'd11); chk("h11_rstn", 32'(rstn), 32'h1);
        hold = 1'b1;
        go(13); chk("h13_cnt", 32'(cnt), 32'd11); chk("h13_busy", 32'(busy), 32'h1);
        go(15); chk("h15_cnt", 32'(cnt), 32'd11);
        hold = 1'b0;
        go(16); chk("h16_cnt", 32'(cnt), 32'd12);
        go(19); chk("h19_rstn", 32'(rstn), 32'h1);
        go(20); chk("h20_rstn", 32'(rstn), 32'h3);
        go(29); chk("h29_done", 32'(done), 32'h0);
        go(30); chk("h30_done", 32'(done), 32'h1); chk("h30_rstn", 32'(rstn), 32'hf);
        do_reset();
        go(17); chk("r17_rstn", 32'(rstn), 32'h3);
        req = 1'b1;
        go(18);
        req = 1'b0;
        chk("r18_rstn", 32'(rstn), 32'h0); chk("r18_cnt", 32'(cnt), 32'd0);
        chk("r18_busy", 32'(busy), 32'h1);
        go(28); chk("r28_rstn", 32'(rstn), 32'h0);
        go(29); chk("r29_rstn", 32'(rstn), 32'h1); chk("r29_cnt", 32'(cnt), 32'd11);
        req = 1'b1;
        hold = 1'b1;
        go(30);
        req = 1'b0;
        chk("rh30_cnt", 32'(cnt), 32'd0); chk("rh30_rstn", 32'(rstn), 32'h0);
        go(32); chk("rh32_cnt", 32'(cnt), 32'd0); chk("rh32_busy", 32'(busy), 32'h1);
        hold = 1'b0;
        go(33); chk("rh33_cnt", 32'(cnt), 32'd1);
        do_reset();
        go(22); chk("m22_rstn", 32'(rstn), 32'h7);
        rst = 1'b1;
        go(23);
        chk("m23_rstn", 32'(rstn), 32'h0); chk("m23_busy", 32'(busy), 32'h0);
        chk("m23_cnt", 32'(cnt), 32'd0); chk("m23_done", 32'(done), 32'h0);
        go(30); chk("m30_done", 32'(done), 32'h0); chk("m30_cnt", 32'(cnt), 32'd0);
        rst = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
